// File: rtl/mau_dot_accumulator.sv
// Dot-product sequencer around the MULT18 multiplier: feeds operand pairs, registers products, accumulates LEN of them.
// Build option: define MAU_DOT_SAT_EN to saturate the accumulator on carry-out instead of wrapping.
module mau_dot_accumulator #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 48
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [17:0]      in_a_i,
  input  logic [17:0]      in_b_i,
  output logic [17:0]      mul_a_o,
  output logic [17:0]      mul_b_o,
  input  logic [35:0]      mul_p_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_acc_o,
  output logic             out_ovf_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [17:0]      mul_a_q, mul_b_q;
  logic             v1_q, v2_q;
  logic [35:0]      prod_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum_s;
  logic             accept_s;
  logic             start_take_s;

  assign accept_s     = in_valid_i && in_ready_q;
  assign start_take_s = (state_q == IDLE) && start_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (len_i != '0) ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (rem_q == LEN_W'(1))) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      // Wait for the last product to leave S2 and land in the accumulator.
      DRAIN: begin
        if (!v1_q && !v2_q) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered, so they are derived from the next state.
  always_comb begin
    in_ready_d  = (state_d == RUN) && (rem_d != '0);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_comb begin
    rem_d = rem_q;
    if (start_take_s) begin
      rem_d = len_i;
    end else if (accept_s) begin
      rem_d = rem_q - LEN_W'(1);
    end else begin
      rem_d = rem_q;
    end
  end

  always_comb begin
    sum_s = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (start_take_s) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (v2_q) begin
      ovf_d = ovf_q | sum_s[ACC_W];
`ifdef MAU_DOT_SAT_EN
      acc_d = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
`else
      acc_d = sum_s[ACC_W-1:0];
`endif
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= 18'd0;
      mul_b_q     <= 18'd0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      prod_q      <= 36'd0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      // Operands hold their last value when idle to keep the multiplier quiet.
      if (accept_s) begin
        mul_a_q <= in_a_i;
        mul_b_q <= in_b_i;
      end
      v1_q <= accept_s;
      v2_q <= v1_q;
      if (v1_q) begin
        prod_q <= mul_p_i;
      end
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign out_acc_o   = acc_q;
  assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_mau_dot_accumulator.sv
// Bench for mau_dot_accumulator: a 48-bit and a 36-bit accumulator instance share stimulus;
// results are compared with an arithmetic dot-product model (MAU_DOT_SAT_EN selects saturating expectations).
module tb_mau_dot_accumulator;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [17:0] in_a, in_b;

  logic        in_ready48, out_valid48, ovf48, busy48;
  logic [17:0] mul_a48, mul_b48;
  logic [35:0] mul_p48;
  logic [47:0] acc48;

  logic        in_ready36, out_valid36, ovf36, busy36;
  logic [17:0] mul_a36, mul_b36;
  logic [35:0] mul_p36;
  logic [35:0] acc36;

  logic [17:0] va [256];
  logic [17:0] vb [256];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Behavioural MULT18: combinational unsigned multiply.
  assign mul_p48 = {18'd0, mul_a48} * {18'd0, mul_b48};
  assign mul_p36 = {18'd0, mul_a36} * {18'd0, mul_b36};

  mau_dot_accumulator #(.LEN_W(8), .ACC_W(48)) dut48 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .len_i(len),
    .in_valid_i(in_valid), .in_ready_o(in_ready48), .in_a_i(in_a), .in_b_i(in_b),
    .mul_a_o(mul_a48), .mul_b_o(mul_b48), .mul_p_i(mul_p48),
    .out_valid_o(out_valid48), .out_ready_i(out_ready), .out_acc_o(acc48),
    .out_ovf_o(ovf48), .busy_o(busy48)
  );

  mau_dot_accumulator #(.LEN_W(8), .ACC_W(36)) dut36 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .len_i(len),
    .in_valid_i(in_valid), .in_ready_o(in_ready36), .in_a_i(in_a), .in_b_i(in_b),
    .mul_a_o(mul_a36), .mul_b_o(mul_b36), .mul_p_i(mul_p36),
    .out_valid_o(out_valid36), .out_ready_i(out_ready), .out_acc_o(acc36),
    .out_ovf_o(ovf36), .busy_o(busy36)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_acc(input logic [63:0] tot, input int w);
    logic [63:0] lim;
    lim = 64'd1 << w;
    if (tot >= lim) begin
`ifdef MAU_DOT_SAT_EN
      return lim - 64'd1;
`else
      return tot & (lim - 64'd1);
`endif
    end
    return tot;
  endfunction

  function automatic logic [63:0] exp_ovf(input logic [63:0] tot, input int w);
    return (tot >= (64'd1 << w)) ? 64'd1 : 64'd0;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {62'd0, in_ready48, in_ready36}, 64'd0);
    chk({tag, "_valid"}, {62'd0, out_valid48, out_valid36}, 64'd0);
    chk({tag, "_ovf"},   {62'd0, ovf48, ovf36}, 64'd0);
    chk({tag, "_busy"},  {62'd0, busy48, busy36}, 64'd0);
    chk({tag, "_acc48"}, {16'd0, acc48}, 64'd0);
    chk({tag, "_acc36"}, {28'd0, acc36}, 64'd0);
    chk({tag, "_mul"},   {28'd0, mul_a48, mul_b48}, 64'd0);
  endtask

  // Feeds pairs va/vb[first..n-1] until accepted; gap idle cycles after every accept.
  task automatic feed(input int n, input int gap, output int got);
    int k;
    logic rdy;
    got = 0;
    k = 0;
    while (got < n && k < 2000) begin
      in_valid = 1'b1;
      in_a = va[got];
      in_b = vb[got];
      rdy = in_ready48;
      step;
      k++;
      if (rdy) begin
        chk("mul_a", {46'd0, mul_a48}, {46'd0, va[got]});
        chk("mul_b", {46'd0, mul_b36}, {46'd0, vb[got]});
        got++;
        if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) step;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_dot(input int n, input int gap, input int hold);
    logic [63:0] tot;
    int got, k;
    tot = 64'd0;
    for (int i = 0; i < n; i++) tot += {46'd0, va[i]} * {46'd0, vb[i]};
    start = 1'b1;
    len = 8'(n);
    step;
    start = 1'b0;
    if (n == 0) begin
      chk("len0_valid", {63'd0, out_valid48}, 64'd1);
      chk("len0_ready", {63'd0, in_ready48}, 64'd0);
    end else begin
      feed(n, gap, got);
      chk("accept_count", 64'(got), 64'(n));
      chk("ready_after_last", {63'd0, in_ready48}, 64'd0);
      k = 0;
      while (!out_valid48 && k < 20) begin
        step;
        k++;
      end
      chk("latency", 64'(gap + k), 64'd3);
    end
    // Hold the result while pulsing start: it must be ignored and outputs stay put.
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      len = 8'd5;
      step;
      chk("hold_valid", {62'd0, out_valid48, out_valid36}, 64'd3);
      chk("hold_acc48", {16'd0, acc48}, exp_acc(tot, 48));
    end
    start = 1'b0;
    chk("acc48", {16'd0, acc48}, exp_acc(tot, 48));
    chk("ovf48", {63'd0, ovf48}, exp_ovf(tot, 48));
    chk("acc36", {28'd0, acc36}, exp_acc(tot, 36));
    chk("ovf36", {63'd0, ovf36}, exp_ovf(tot, 36));
    out_ready = 1'b1;
    start = 1'b1;
    len = 8'd3;
    step;
    out_ready = 1'b0;
    start = 1'b0;
    chk("consumed_valid", {63'd0, out_valid48}, 64'd0);
    step;
    chk("start_in_done_ignored", {62'd0, busy48, busy36}, 64'd0);
  endtask

  initial begin
    int got;
    int n;
    reset = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    out_ready = 1'b0; in_a = 18'd0; in_b = 18'd0;
    repeat (3) step;
    chk_reset_state("reset");
    reset = 1'b0;
    step;

    // T1: (1,2),(3,4),(5,6),(7,8) back-to-back
    for (int i = 0; i < 4; i++) begin
      va[i] = 18'(2 * i + 1);
      vb[i] = 18'(2 * i + 2);
    end
    run_dot(4, 0, 0);

    // T2: single max pair
    va[0] = 18'h3FFFF; vb[0] = 18'h3FFFF;
    run_dot(1, 0, 1);

    // T3: zero length
    run_dot(0, 0, 1);

    // T4: gaps of 2, result held 5 cycles
    va[0] = 18'd1000; vb[0] = 18'd7;
    va[1] = 18'h20000; vb[1] = 18'h3FFFF;
    va[2] = 18'd12345; vb[2] = 18'd54321;
    run_dot(3, 2, 5);

    // T5: two max pairs overflow the 36-bit instance
    va[0] = 18'h3FFFF; vb[0] = 18'h3FFFF;
    va[1] = 18'h3FFFF; vb[1] = 18'h3FFFF;
    run_dot(2, 0, 2);

    // T6: reset after 2 of 4 pairs, then a fresh vector
    for (int i = 0; i < 4; i++) begin
      va[i] = 18'(100 + i);
      vb[i] = 18'(200 + i);
    end
    start = 1'b1; len = 8'd4;
    step;
    start = 1'b0;
    feed(2, 0, got);
    reset = 1'b1;
    step;
    chk_reset_state("midrun_reset");
    reset = 1'b0;
    step;
    va[0] = 18'd2; vb[0] = 18'd3;
    run_dot(1, 0, 0);

    // Randomized vectors, half of them biased towards maximal operands
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        if (t % 2 == 1) begin
          va[i] = 18'h3FFFF - 18'($urandom_range(0, 3));
          vb[i] = 18'h3FFFF - 18'($urandom_range(0, 3));
        end else begin
          va[i] = 18'($urandom_range(0, 18'h3FFFF));
          vb[i] = 18'($urandom_range(0, 18'h3FFFF));
        end
      end
      run_dot(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
